// File: rtl/work_ram_pkg.sv
// Shared definitions for the time-sliced working RAM: scan FSM states, slot phases, lane helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package work_ram_pkg;

   typedef enum logic {
      SCAN_IDLE  = 1'b0,
      SCAN_FETCH = 1'b1
   } scan_state_t;

   // Slot ownership carried by the phase register.
   localparam logic PHASE_CPU  = 1'b0;
   localparam logic PHASE_SCAN = 1'b1;

   // Scan window base for the reference 11-bit / 7-bit configuration.
   localparam logic [10:0] DEFAULT_SCAN_BASE = 11'h700;

   // log2(LANES); zero when a word holds a single byte lane.
   function automatic int lane_sel_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 0;
   endfunction

   // All-ones top bits, low SCAN_W+1 bits clear: the window sits at the top of the RAM.
   function automatic int default_scan_base(input int addr_w, input int scan_w);
      return ((1 << addr_w) - 1) & ~((1 << (scan_w + 1)) - 1);
   endfunction

endpackage

// File: rtl/wram_lane.sv
// One byte lane of the working RAM: 2^ADDR_W x 8 single-port synchronous RAM.
// Latency: read data on q one clk after an enabled access (read-before-write).
// Backpressure: none; accepts an access every clk when en is high.
module wram_lane #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        q
);

   logic [7:0] mem [2**ADDR_W];

   // Enabled slot: optional write, and the old contents always land on q.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         q <= mem[addr];
      end
   end

endmodule

// File: rtl/shared_work_ram.sv
// CPU / video scan-out shared working RAM, alternating slots on ce; optional clear engine under WORK_RAM_CLEAR_EN.
// Latency: CPU ack and read byte one clk after its CPU slot; scan word one clk after each scan slot.
// Backpressure: cpu_req is held until cpu_ack; scan_start is dropped while a burst or the clear engine runs.
module shared_work_ram
   import work_ram_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int ADDR_W = 11,
   parameter int SCAN_W = 7,
   parameter logic [ADDR_W-1:0] SCAN_BASE = ADDR_W'(default_scan_base(ADDR_W, SCAN_W)),
   localparam int LSW = lane_sel_w(LANES),
   localparam int LIW = (LSW > 0) ? LSW : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ce,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [ADDR_W+LSW-1:0]   cpu_addr,
   input  logic [7:0]              cpu_wdata,
   output logic [7:0]              cpu_rdata,
   output logic                    cpu_ack,
   input  logic                    scan_start,
   input  logic                    buf_sel,
   input  logic [SCAN_W:0]         scan_count,
   output logic                    scan_valid,
   output logic [SCAN_W-1:0]       scan_idx,
   output logic [8*LANES-1:0]      scan_data,
   output logic                    scan_busy,
   output logic                    init_busy
);

   logic                phase;
   scan_state_t         state, state_nxt;
   logic [SCAN_W-1:0]   idx, idx_nxt;
   logic [SCAN_W:0]     cnt, cnt_nxt;
   logic                sel, sel_nxt;
   logic                clr_we;
   logic [ADDR_W-1:0]   clr_addr;
   logic [ADDR_W-1:0]   cpu_word;
   logic [LIW-1:0]      cpu_lane;
   logic                cpu_slot, scan_slot, scan_accept;
   logic                ram_en;
   logic [ADDR_W-1:0]   ram_addr;
   logic [LANES-1:0]    ram_we;
   logic [7:0]          ram_wdata;
   logic [7:0]          lane_q [LANES];
   logic [8*LANES-1:0]  word_q;
   logic                rd_pend;
   logic [LIW-1:0]      rd_lane;
   logic [7:0]          rdata_hold;
   logic [8*LANES-1:0]  scan_hold;

   assign cpu_word = cpu_addr[LSW +: ADDR_W];

   generate
      if (LSW > 0) begin : g_lane_sel
         assign cpu_lane = cpu_addr[LSW-1:0];
      end else begin : g_one_lane
         assign cpu_lane = 1'b0;
      end
   endgenerate

`ifdef WORK_RAM_CLEAR_EN
   logic init_q;

   // Clear engine: one zeroed word per ce from address 0 up, then hand the RAM over.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_q   <= 1'b1;
         clr_addr <= '0;
      end else if (init_q && ce) begin
         clr_addr <= clr_addr + 1'b1;
         if (&clr_addr) begin
            init_q <= 1'b0;
         end
      end
   end

   assign init_busy = init_q;
   assign clr_we    = init_q & ce;
`else
   assign init_busy = 1'b0;
   assign clr_we    = 1'b0;
   assign clr_addr  = '0;
`endif

   // A held request is served only in a CPU slot and never while its ack is still showing.
   assign cpu_slot    = ce & (phase == PHASE_CPU) & cpu_req & ~cpu_ack & ~init_busy;
   assign scan_slot   = ce & (phase == PHASE_SCAN) & (state == SCAN_FETCH);
   assign scan_accept = scan_start & (scan_count != '0) & ~scan_busy & ~init_busy;

   // Slot phase: advances only on ce so both owners see the same share of bandwidth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= PHASE_CPU;
      end else if (ce) begin
         phase <= ~phase;
      end
   end

   // Scan FSM state and burst context.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SCAN_IDLE;
         idx   <= '0;
         cnt   <= '0;
         sel   <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
         sel   <= sel_nxt;
      end
   end

   // Scan FSM next state: buf_sel and count are frozen at start, idx walks to count-1.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      sel_nxt   = sel;
      case (state)
         SCAN_IDLE: begin
            if (scan_accept) begin
               state_nxt = SCAN_FETCH;
               idx_nxt   = '0;
               cnt_nxt   = scan_count;
               sel_nxt   = buf_sel;
            end
         end
         SCAN_FETCH: begin
            if (scan_slot) begin
               idx_nxt = idx + 1'b1;
               if ({1'b0, idx} == cnt - 1'b1) begin
                  state_nxt = SCAN_IDLE;
               end
            end
         end
         default: state_nxt = SCAN_IDLE;
      endcase
   end

   // RAM port owner for this clk: clear engine, else CPU slot, else scan slot.
   always_comb begin
      ram_en    = 1'b0;
      ram_addr  = '0;
      ram_we    = '0;
      ram_wdata = 8'h00;
      if (clr_we) begin
         ram_en   = 1'b1;
         ram_addr = clr_addr;
         ram_we   = '1;
      end else if (cpu_slot) begin
         ram_en    = 1'b1;
         ram_addr  = cpu_word;
         ram_we    = cpu_we ? (LANES'(1) << cpu_lane) : '0;
         ram_wdata = cpu_wdata;
      end else if (scan_slot) begin
         ram_en   = 1'b1;
         ram_addr = SCAN_BASE | ADDR_W'({sel, idx});
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      wram_lane #(.ADDR_W(ADDR_W)) u_lane (
         .clk   (clk),
         .en    (ram_en),
         .we    (ram_we[l]),
         .addr  (ram_addr),
         .wdata (ram_wdata),
         .q     (lane_q[l])
      );
   end

   // Assemble the full word, lane 0 in the LSBs.
   always_comb begin
      word_q = '0;
      for (int l = 0; l < LANES; l++) begin
         word_q[8*l +: 8] = lane_q[l];
      end
   end

   // CPU completion: ack pulse, and capture of the read byte so later slots cannot disturb it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_ack    <= 1'b0;
         rd_pend    <= 1'b0;
         rd_lane    <= '0;
         rdata_hold <= 8'h00;
      end else begin
         cpu_ack <= cpu_slot;
         rd_pend <= cpu_slot & ~cpu_we;
         if (cpu_slot) begin
            rd_lane <= cpu_lane;
         end
         if (cpu_ack && rd_pend) begin
            rdata_hold <= lane_q[rd_lane];
         end
      end
   end

   // RAM output is live only in the ack clk; otherwise present the held byte.
   assign cpu_rdata = (cpu_ack && rd_pend) ? lane_q[rd_lane] : rdata_hold;

   // Scan outputs: valid/idx per scan slot, busy spans the burst through the last valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_valid <= 1'b0;
         scan_idx   <= '0;
         scan_busy  <= 1'b0;
         scan_hold  <= '0;
      end else begin
         scan_valid <= scan_slot;
         scan_busy  <= (state_nxt == SCAN_FETCH) | scan_slot;
         if (scan_slot) begin
            scan_idx <= idx;
         end
         if (scan_valid) begin
            scan_hold <= word_q;
         end
      end
   end

   assign scan_data = scan_valid ? word_q : scan_hold;

endmodule
